// File: rtl/comparador_serial_id.sv
// comparador_serial_id
//   Sequential MSB-first magnitude comparator. Two K-bit operands are captured
//   on an accepted start and examined one bit pair per clock, from the MSB down.
//   The first differing bit pair decides the result. If no pair differs, the
//   operands are equal.
//
//   State table
//     state   | meaning
//     IDLE    | waiting for start; result flags hold the last result
//     COMPARE | one bit pair examined per cycle; busy = 1
//     DONE    | single-cycle done pulse; flags are valid from this cycle
//
//   Optional build macro: COMP_EARLY_EXIT_EN
//     When defined, COMPARE ends on the first differing bit pair, or when the
//     last bit pair has been examined. When undefined, COMPARE always runs K
//     cycles. The result is the same in both builds.

module comparador_serial_id #(
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] a_in,
    input  logic [K-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic         mayor,
    output logic         menor,
    output logic         igual
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state;
    logic [K-1:0]  a_sh;
    logic [K-1:0]  b_sh;
    logic [CW-1:0] cnt;
    logic          decided;

    logic          a_bit;
    logic          b_bit;
    logic          bits_differ;
    logic          first_diff;
    logic          last_bit;
    logic          finish;

    // Decode the bit pair currently at the top of the shift registers.
    always_comb begin
        a_bit       = a_sh[K-1];
        b_bit       = b_sh[K-1];
        bits_differ = a_bit ^ b_bit;
        first_diff  = bits_differ & ~decided;
        last_bit    = (cnt == '0);
`ifdef COMP_EARLY_EXIT_EN
        finish      = last_bit | first_diff;
`else
        finish      = last_bit;
`endif
    end

    // Control FSM. The datapath and the registered outputs are updated here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mayor   <= 1'b0;
            menor   <= 1'b0;
            igual   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        cnt     <= CNT_LOAD;
                        decided <= 1'b0;
                        mayor   <= 1'b0;
                        menor   <= 1'b0;
                        igual   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= COMPARE;
                    end
                end

                COMPARE: begin
                    a_sh <= {a_sh[K-2:0], 1'b0};
                    b_sh <= {b_sh[K-2:0], 1'b0};
                    // The counter stops at zero. It is reloaded on the next
                    // accept, so it never wraps.
                    if (!last_bit) begin
                        cnt <= cnt - 1'b1;
                    end
                    // Only the most significant differing pair decides the result.
                    if (first_diff) begin
                        mayor   <= a_bit;
                        menor   <= b_bit;
                        decided <= 1'b1;
                    end
                    if (finish) begin
                        if (!decided && !bits_differ) begin
                            igual <= 1'b1;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Simulation-only sanity properties. Synthesis does not build these.
    // The result flags must be one-hot whenever done pulses.
    property p_onehot_at_done;
        @(posedge clk) disable iff (!rst_n) done |-> $onehot({mayor, menor, igual});
    endproperty
    a_onehot_at_done: assert property (p_onehot_at_done);

    // busy and done never overlap.
    property p_busy_done_excl;
        @(posedge clk) disable iff (!rst_n) !(busy && done);
    endproperty
    a_busy_done_excl: assert property (p_busy_done_excl);

    // done is a single-cycle pulse.
    property p_done_single;
        @(posedge clk) disable iff (!rst_n) done |=> !done;
    endproperty
    a_done_single: assert property (p_done_single);

endmodule

// File: tb/tb_comparador_serial_id.sv
module tb_comparador_serial_id;

    localparam int K = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [K-1:0] a_in;
    logic [K-1:0] b_in;
    logic         busy;
    logic         done;
    logic         mayor;
    logic         menor;
    logic         igual;

    int checks   = 0;
    int failures = 0;

    comparador_serial_id #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .mayor (mayor),
        .menor (menor),
        .igual (igual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the expected flags come from integer comparison.
    function automatic logic [2:0] ref_flags(input logic [K-1:0] a, input logic [K-1:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        return {ia > ib, ia < ib, ia == ib};
    endfunction

    // Reference model: the number of cycles from the accept cycle to the done cycle.
    function automatic int ref_latency(input logic [K-1:0] a, input logic [K-1:0] b);
        int lat;
        lat = K + 1;
`ifdef COMP_EARLY_EXIT_EN
        begin
            logic [K-1:0] x;
            x = a ^ b;
            for (int p = K - 1; p >= 0; p--) begin
                if (x[p]) begin
                    lat = (K - 1 - p) + 2;
                    break;
                end
            end
        end
`endif
        return lat;
    endfunction

    // Run one operation and check its latency, busy, flags and the idle cycle after it.
    // When interfere is set, the task pulses start with other operands during COMPARE.
    task automatic run_op(input logic [K-1:0] a, input logic [K-1:0] b,
                          input bit interfere, input string tag);
        int n;
        logic [2:0] ef;
        int el;
        ef = ref_flags(a, b);
        el = ref_latency(a, b);
        @(posedge clk); #1;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!done && n < 4 * K) begin
            if (interfere && n == 3) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = a;
            end else if (interfere && n == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, n, el);
        chk({tag, "_flags"}, {29'd0, mayor, menor, igual}, {29'd0, ef});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, {29'd0, mayor, menor, igual}, {29'd0, ef});
        if (interfere) begin
            @(posedge clk); #1;
            chk({tag, "_no_second"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    initial begin
        logic [K-1:0] ra;
        logic [K-1:0] rb;
        int c;
        int last;
        int pulses;
        int el;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {27'd0, busy, done, mayor, menor, igual}, 32'd0);
        rst_n = 1'b1;

        run_op(8'hA5, 8'hA5, 1'b0, "eq_a5");
        run_op(8'h80, 8'h7F, 1'b0, "msb_gt");
        run_op(8'h3C, 8'h3D, 1'b0, "lsb_lt");
        run_op(8'h00, 8'h00, 1'b0, "zero_eq");
        run_op(8'hFF, 8'hFE, 1'b0, "lsb_gt");
        // Lower bits disagree the other way after the deciding bit.
        run_op(8'h40, 8'h3F, 1'b0, "later_diff");
        run_op(8'h5A, 8'h5A, 1'b1, "ignore_start");

        // Assert reset in the 3rd COMPARE cycle.
        @(posedge clk); #1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out", {27'd0, busy, done, mayor, menor, igual}, 32'd0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", {27'd0, busy, done, mayor, menor, igual}, 32'd0);
        run_op(8'h12, 8'h34, 1'b0, "after_abort");

        // Hold start high for back-to-back operations.
        el = ref_latency(8'h00, 8'hFF);
        @(posedge clk); #1;
        a_in  = 8'h00;
        b_in  = 8'hFF;
        start = 1'b1;
        c = 0;
        last = -1;
        pulses = 0;
        while (pulses < 4 && c < 20 * K) begin
            @(posedge clk); #1;
            c++;
            if (done) begin
                if (last < 0) chk("b2b_first", c, el);
                else          chk("b2b_period", c - last, el + 1);
                chk("b2b_flags", {29'd0, mayor, menor, igual}, 32'b010);
                last = c;
                pulses++;
            end
        end
        chk("b2b_pulses", pulses, 4);
        start = 1'b0;
        repeat (K + 3) @(posedge clk);

        // Random operations. Equal operands and single-bit differences are
        // mixed in to cover every decision position.
        for (int i = 0; i < 40; i++) begin
            ra = K'($urandom);
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ K'(1 << $urandom_range(K - 1, 0));
                default: rb = K'($urandom);
            endcase
            run_op(ra, rb, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
